// File: rtl/uart_mmio_fifo_if.sv
// Core data-bus port of the memory-mapped UART (address, store/load strobes, data).
// Latency: none, a bundle of wires; read_data is combinational in the slave.
// Backpressure: wait_request (slave->master) holds a store to DATA while the TX FIFO is full.
interface uart_mmio_fifo_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;
    logic        wait_request;

    modport master (output address, write_data, mem_write, mem_read,
                    input  read_data, wait_request);
    modport slave  (input  address, write_data, mem_write, mem_read,
                    output read_data, wait_request);
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with RX/TX FIFOs, divisor, control, sticky errors, level irq.
// Latency: loads combinational; stores and pops take effect on the next clk edge.
// Backpressure: stores to DATA stall via wait_request while TX is full; RX drops on full (overrun).
// Optional build macro UART_LOOPBACK_EN adds CTRL bit3 (internal tx->rx loopback, tx pin held high).

module uart_mmio_fifo_buf #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic [AW:0]  level,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign do_pop   = pop_vld & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full buffer is accepted then
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    // wrapping pointers and level; push+pop together leave the level unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push & ~do_pop)      level <= level + 1'b1;
            else if (do_pop & ~do_push) level <= level - 1'b1;
        end
    end

    // storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module uart_mmio_fifo #(
    parameter logic [31:0] UART_BASE   = 32'h1000_0000,
    parameter int          RX_FIFO_AW  = 4,
    parameter int          TX_FIFO_AW  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            tx,
    output logic            irq,
    uart_mmio_fifo_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

`ifdef UART_LOOPBACK_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic [31:0] offset;
    logic        sel;
    logic [1:0]  reg_idx;
    logic        data_wr, status_wr, ctrl_wr, div_wr, data_rd;
    logic [3:0]  ctrl;
    logic [15:0] div;
    logic        overrun, frame_err;
    logic [15:0] tick_cnt;
    logic        tick;
    logic        unused_bits;

    // FIFO side
    logic [7:0]            tx_head, rx_head;
    logic [TX_FIFO_AW:0]   tx_level;
    logic [RX_FIFO_AW:0]   rx_level;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_push, tx_pop, rx_push, rx_pop;

    // engines
    state_t     tx_state, tx_state_nxt, rx_state, rx_state_nxt;
    logic [3:0] tx_tcnt, rx_tcnt;
    logic [2:0] tx_bitcnt, rx_bitcnt;
    logic [7:0] tx_shift, rx_shift;
    logic       tx_reg, tx_bit_end;
    logic       rx_in, rx_s1, rx_s2, rx_mid, rx_bit_end, ov_set, fe_set;

    assign offset      = bus.address - UART_BASE;
    assign sel         = (offset < 32'd16);
    assign reg_idx     = bus.address[3:2];
    assign data_wr     = sel & bus.mem_write & (reg_idx == 2'd0);
    assign status_wr   = sel & bus.mem_write & (reg_idx == 2'd1);
    assign ctrl_wr     = sel & bus.mem_write & (reg_idx == 2'd2);
    assign div_wr      = sel & bus.mem_write & (reg_idx == 2'd3);
    assign data_rd     = sel & bus.mem_read  & (reg_idx == 2'd0);
    assign unused_bits = &{1'b0, bus.write_data[31:16]};

    assign bus.wait_request = data_wr & tx_full;
    assign tx_push          = data_wr & ~tx_full;
    assign rx_pop           = data_rd;

    uart_mmio_fifo_buf #(.AW(TX_FIFO_AW), .W(8)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_vld(tx_push), .push_dat(bus.write_data[7:0]),
        .pop_vld(tx_pop), .head_dat(tx_head), .level(tx_level), .empty(tx_empty), .full(tx_full)
    );

    uart_mmio_fifo_buf #(.AW(RX_FIFO_AW), .W(8)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_vld(rx_push), .push_dat(rx_shift),
        .pop_vld(rx_pop), .head_dat(rx_head), .level(rx_level), .empty(rx_empty), .full(rx_full)
    );

`ifdef UART_LOOPBACK_EN
    assign tx    = ctrl[3] ? 1'b1 : tx_reg;
    assign rx_in = ctrl[3] ? tx_reg : rx;
`else
    assign tx    = tx_reg;
    assign rx_in = rx;
`endif

    assign irq = (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) | (ctrl[2] & (overrun | frame_err));

    // combinational load mux, zero outside the window
    always_comb begin
        bus.read_data = '0;
        if (sel) begin
            case (reg_idx)
                2'd0: bus.read_data = rx_empty ? 32'd0 : {24'd0, rx_head};
                2'd1: bus.read_data = {8'd0, 8'(tx_level), 8'(rx_level), 2'b00, frame_err, overrun,
                                       rx_full, tx_empty, tx_full, rx_empty};
                2'd2: bus.read_data = {28'd0, ctrl};
                default: bus.read_data = {16'd0, div};
            endcase
        end
    end

    // CSRs; a newly detected error wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            div       <= DEFAULT_DIV;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= bus.write_data[3:0] & CTRL_MASK;
            if (div_wr)  div  <= bus.write_data[15:0];
            overrun   <= ov_set | (overrun   & ~(status_wr & bus.write_data[4]));
            frame_err <= fe_set | (frame_err & ~(status_wr & bus.write_data[5]));
        end
    end

    // oversample tick: one pulse every DIV+1 clocks, restarted by a DIV write
    assign tick = (tick_cnt == div);
    always_ff @(posedge clk) begin
        if (reset || div_wr) tick_cnt <= '0;
        else if (tick)       tick_cnt <= '0;
        else                 tick_cnt <= tick_cnt + 16'd1;
    end

    // engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            rx_state <= S_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    // TX next state: each of start/8 data/stop lasts 16 ticks
    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_bit_end   = tick & (tx_tcnt == 4'd15);
        case (tx_state)
            S_IDLE:  if (tick & ~tx_empty) begin
                         tx_state_nxt = S_START;
                         tx_pop       = 1'b1;
                     end
            S_START: if (tx_bit_end) tx_state_nxt = S_DATA;
            S_DATA:  if (tx_bit_end && tx_bitcnt == 3'd7) tx_state_nxt = S_STOP;
            default: if (tx_bit_end) tx_state_nxt = S_IDLE;
        endcase
    end

    // TX datapath: line register, LSB-first shifter, tick and bit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_reg    <= 1'b1;
            tx_tcnt   <= '0;
            tx_bitcnt <= '0;
            tx_shift  <= '0;
        end else begin
            if (tx_state == S_IDLE) tx_tcnt <= '0;
            else if (tick)          tx_tcnt <= tx_tcnt + 4'd1;
            case (tx_state)
                S_IDLE:  if (tx_pop) begin
                             tx_shift <= tx_head;
                             tx_reg   <= 1'b0;
                         end
                S_START: if (tx_bit_end) begin
                             tx_reg    <= tx_shift[0];
                             tx_bitcnt <= '0;
                         end
                S_DATA:  if (tx_bit_end) begin
                             if (tx_bitcnt == 3'd7) begin
                                 tx_reg <= 1'b1;
                             end else begin
                                 tx_shift  <= tx_shift >> 1;
                                 tx_reg    <= tx_shift[1];
                                 tx_bitcnt <= tx_bitcnt + 3'd1;
                             end
                         end
                default: ;
            endcase
        end
    end

    // RX next state: verify start at mid-bit, sample data/stop every 16 ticks
    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        ov_set       = 1'b0;
        fe_set       = 1'b0;
        rx_mid       = tick & (rx_tcnt == 4'd7);
        rx_bit_end   = tick & (rx_tcnt == 4'd15);
        case (rx_state)
            S_IDLE:  if (~rx_s2) rx_state_nxt = S_START;
            S_START: if (rx_mid) rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_end && rx_bitcnt == 3'd7) rx_state_nxt = S_STOP;
            default: if (rx_bit_end) begin
                         rx_state_nxt = S_IDLE;
                         if (~rx_s2)                        fe_set  = 1'b1;
                         else if (rx_full & ~rx_pop)        ov_set  = 1'b1;
                         else                               rx_push = 1'b1;
                     end
        endcase
    end

    // RX datapath: 2-flop synchroniser, tick/bit counters, LSB-first shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_tcnt   <= '0;
            rx_bitcnt <= '0;
            rx_shift  <= '0;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            case (rx_state)
                S_IDLE:  rx_tcnt <= '0;
                S_START: begin
                             if (rx_mid)    rx_tcnt <= '0;
                             else if (tick) rx_tcnt <= rx_tcnt + 4'd1;
                             rx_bitcnt <= '0;
                         end
                default: if (tick) rx_tcnt <= rx_tcnt + 4'd1;
            endcase
            if (rx_state == S_DATA && rx_bit_end) begin
                rx_shift  <= {rx_s2, rx_shift[7:1]};
                rx_bitcnt <= rx_bitcnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: randomized serial and bus traffic against a queue model.
// Expected loads and tx frames are queued at stimulus time and checked by independent monitors.
// Runs with DIV=0 (16 clocks per serial bit), TX depth 4, RX depth 16.
module tb_uart_mmio_fifo;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int RX_DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic tx, irq;

    uart_mmio_fifo_if bus();

    uart_mmio_fifo #(
        .UART_BASE(BASE), .RX_FIFO_AW(4), .TX_FIFO_AW(2), .DEFAULT_DIV(16'd26)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .irq(irq), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t     rd_q[$];      // expected load results, in issue order
    byte unsigned tx_q[$];     // bytes expected on the tx pin, in order
    byte unsigned rx_model[$]; // bytes the RX FIFO should hold
    bit          m_ov, m_fe;
    logic [2:0]  m_ctrl;
    bit          mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        int lvl;
        lvl = rx_model.size();
        // TX is idle whenever the bench reads STATUS
        return {16'd0, 8'(lvl), 2'b00, m_fe, m_ov, (lvl == RX_DEPTH), 1'b1, 1'b0, (lvl == 0)};
    endfunction

    function automatic logic irq_exp();
        return (m_ctrl[0] && rx_model.size() != 0) || m_ctrl[1] || (m_ctrl[2] && (m_ov || m_fe));
    endfunction

    // load monitor: every selected load cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.mem_read && (bus.address - BASE) < 32'd16) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected no load", bus.read_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.name, bus.read_data, e.val);
            end
        end
    end

    // tx monitor: decode each frame at mid-bit and compare with the queued byte
    initial begin
        logic [9:0] f;
        byte unsigned e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                repeat (7) @(negedge clk);
                f[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (16) @(negedge clk);
                    f[i] = tx;
                end
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got frame %b expected none", f);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_frame", {22'd0, f}, {22'd0, 1'b1, e, 1'b0});
                end
            end
        end
    end

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d, output int stall);
        stall = 0;
        @(posedge clk); #1;
        bus.address    = BASE + 32'(off);
        bus.write_data = d;
        bus.mem_write  = 1'b1;
        @(negedge clk);
        while (bus.wait_request === 1'b1 && stall < 1000) begin
            stall++;
            @(negedge clk);
        end
        if (stall >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_timeout: got wait_request stuck expected release");
        end
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        case (off[3:2])
            2'd0: tx_q.push_back(d[7:0]);
            2'd1: begin
                      if (d[4]) m_ov = 1'b0;
                      if (d[5]) m_fe = 1'b0;
                  end
            2'd2: m_ctrl = d[2:0];
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [3:0] off, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        @(posedge clk); #1;
        bus.address  = BASE + 32'(off);
        bus.mem_read = 1'b1;
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic read_rx_byte(input string name);
        byte unsigned b;
        b = rx_model.pop_front();
        bus_read(4'h0, {24'd0, b}, name);
    endtask

    task automatic send_frame(input byte unsigned b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        if (!stop)                         m_fe = 1'b1;
        else if (rx_model.size() < RX_DEPTH) rx_model.push_back(b);
        else                               m_ov = 1'b1;
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_drain_timeout: got %0d bytes pending expected 0", tx_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        byte unsigned b;
        bus.address = '0; bus.write_data = '0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
        m_ov = 1'b0; m_fe = 1'b0; m_ctrl = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        bus_read(4'h4, 32'h0000_0005, "reset_status");
        bus_read(4'h8, 32'd0, "reset_ctrl");
        bus_read(4'hC, 32'd26, "reset_div");
        bus_read(4'h0, 32'd0, "empty_data_read");

        // out-of-window load returns zero
        @(posedge clk); #1;
        bus.address = BASE + 32'd16; bus.mem_read = 1'b1;
        @(negedge clk);
        check("out_of_window", bus.read_data, 32'd0);
        @(posedge clk); #1 bus.mem_read = 1'b0;

        // register access, low address bits ignored, CTRL bit3 absent
        bus_write(4'hC, 32'hFFFF_0000, st);
        bus_read(4'hE, 32'd0, "div_write_0");
        bus_write(4'h8, 32'h0000_000F, st);
        bus_read(4'hB, 32'h0000_0007, "ctrl_mask");
        bus_write(4'h8, 32'd0, st);

        // TX 0x55: tx falls within one tick, then frame checked by monitor
        bus_write(4'h0, 32'h0000_0055, st);
        repeat (2) @(negedge clk);
        check("tx_start_fall", {31'd0, tx}, 32'd0);
        wait_tx_idle();
        bus_read(4'h4, status_exp(), "status_after_tx");

        // TX stall: one byte in flight, four fill the FIFO, the next must stall for ~a frame
        bus_write(4'h0, 32'($urandom_range(0, 255)), st);
        for (int i = 0; i < 4; i++) begin
            bus_write(4'h0, 32'($urandom_range(0, 255)), st);
            check("fill_no_stall", st, 32'd0);
        end
        bus_write(4'h0, 32'($urandom_range(0, 255)), st);
        check("fifth_stall_len_ok", {31'd0, (st >= 140 && st <= 170)}, 32'd1);
        wait_tx_idle();

        // RX 0xA3
        send_frame(8'hA3, 1'b1);
        bus_read(4'h4, status_exp(), "status_rx_one");
        read_rx_byte("rx_a3");
        bus_read(4'h4, status_exp(), "status_rx_drained");

        // random RX bytes
        for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        bus_read(4'h4, status_exp(), "status_rx_five");
        for (int i = 0; i < 5; i++) read_rx_byte("rx_rand");

        // rx_ie and tx_ie interrupts
        bus_write(4'h8, 32'd1, st);
        @(negedge clk);
        check("irq_rx_empty", {31'd0, irq}, {31'd0, irq_exp()});
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        @(negedge clk);
        check("irq_rx_data", {31'd0, irq}, {31'd0, irq_exp()});
        read_rx_byte("rx_irq_byte");
        @(negedge clk);
        check("irq_rx_popped", {31'd0, irq}, {31'd0, irq_exp()});
        bus_write(4'h8, 32'd2, st);
        @(negedge clk);
        check("irq_tx_empty", {31'd0, irq}, {31'd0, irq_exp()});
        bus_write(4'h8, 32'd0, st);

        // overrun: 16 bytes fill RX, the 17th is dropped
        for (int i = 0; i < RX_DEPTH + 1; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        bus_read(4'h4, status_exp(), "status_overrun");
        bus_write(4'h8, 32'd4, st);
        @(negedge clk);
        check("irq_err_set", {31'd0, irq}, {31'd0, irq_exp()});
        bus_write(4'h4, 32'h0000_0010, st);
        @(negedge clk);
        check("irq_err_cleared", {31'd0, irq}, {31'd0, irq_exp()});
        bus_read(4'h4, status_exp(), "status_ov_cleared");
        for (int i = 0; i < RX_DEPTH; i++) read_rx_byte("rx_full_drain");

        // frame error and start glitch
        send_frame(8'h5A, 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b0);
        repeat (20) @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        bus_read(4'h4, status_exp(), "status_frame_err");
        @(negedge clk);
        check("irq_frame_err", {31'd0, irq}, {31'd0, irq_exp()});
        bus_write(4'h4, 32'h0000_0020, st);
        bus_read(4'h4, status_exp(), "status_fe_cleared");
        read_rx_byte("rx_after_fe");

        // reset in the middle of data bit 3 of a TX frame
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        bus_write(4'h8, 32'd3, st);
        mon_en = 1'b0;
        bus_write(4'h0, 32'h0000_00C3, st);
        void'(tx_q.pop_back());
        repeat (2 + 64 + 8) @(posedge clk);
        @(negedge clk);
        check("irq_before_reset", {31'd0, irq}, {31'd0, irq_exp()});
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        rx_model.delete();
        m_ov = 1'b0; m_fe = 1'b0; m_ctrl = 3'd0;
        @(negedge clk);
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        check("midframe_reset_irq", {31'd0, irq}, 32'd0);
        bus_read(4'h4, 32'h0000_0005, "midframe_reset_status");
        bus_read(4'hC, 32'd26, "midframe_reset_div");
        bus_read(4'h8, 32'd0, "midframe_reset_ctrl");

        repeat (10) @(posedge clk);
        if (rd_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_pending: got %0d unchecked loads expected 0", rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
